// File: rtl/riscv_pkg.sv
// Shared writeback-stage types: writeback source select, load funct3 codes, FSM states.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_RSV = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction and alignment checks (purely combinational).
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

  // Select/extend the addressed lane and flag bad size/offset combinations.
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      F3_LW: begin
        data       = rdata;
        misaligned = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU / load / link value, waits for load data with a
// timeout, and drives a registered register-file write port.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            reg_write,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
  output logic            load_fault
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  wb_state_e       state;
  logic [CW-1:0]   cnt;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic [2:0]      f3_q;
  logic [1:0]      addr_q;

  logic [2:0]      la_f3;
  logic [1:0]      la_addr;
  logic [XLEN-1:0] la_data;
  logic            la_mis;
  logic            la_ill;
  logic            in_wr_ok;

  assign in_ready = (state != WAIT_MEM);
  assign in_wr_ok = in_wen && (in_rd != 5'd0);

  // While waiting, the aligner works on the held load; otherwise it checks the incoming one.
  assign la_f3   = (state == WAIT_MEM) ? f3_q   : in_funct3;
  assign la_addr = (state == WAIT_MEM) ? addr_q : in_alu_result[1:0];

  load_align #(.XLEN(XLEN)) u_align (
    .funct3     (la_f3),
    .addr       (la_addr),
    .rdata      (dmem_rdata),
    .data       (la_data),
    .misaligned (la_mis),
    .illegal    (la_ill)
  );

  // FSM with registered write port; reg_write/load_fault default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      reg_write  <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      load_fault <= 1'b0;
    end else begin
      reg_write  <= 1'b0;
      load_fault <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (in_valid) begin
            rd_q   <= in_rd;
            wen_q  <= in_wen;
            f3_q   <= in_funct3;
            addr_q <= in_alu_result[1:0];
            case (wb_sel_e'(in_wb_sel))
              WB_ALU: begin
                state     <= COMMIT;
                reg_write <= in_wr_ok;
                waddr     <= in_rd;
                wdata     <= in_alu_result;
              end
              WB_PC4: begin
                state     <= COMMIT;
                reg_write <= in_wr_ok;
                waddr     <= in_rd;
                wdata     <= in_pc_plus4;
              end
              WB_MEM: begin
                if (la_mis || la_ill) begin
                  state      <= COMMIT;
                  waddr      <= in_rd;
                  load_fault <= 1'b1;
                end else begin
                  state <= WAIT_MEM;
                  cnt   <= '0;
                end
              end
              WB_RSV: begin
                state <= COMMIT;
                waddr <= in_rd;
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (dmem_rvalid) begin
            state     <= COMMIT;
            reg_write <= wen_q && (rd_q != 5'd0);
            waddr     <= rd_q;
            wdata     <= la_data;
          end else if (cnt == CW'(LOAD_TIMEOUT - 1)) begin
            state      <= IDLE;
            load_fault <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
